// File: rtl/cfg_frame_writer.sv
// cfg_frame_writer: streams {address,data} words into frame config memories as setup/enable-pulse/hold writes; CFG_PARITY_CHECK_EN enables even-parity word checking
module cfg_frame_writer #(
  parameter int ADDR_W    = 7,
  parameter int NUM_WORDS = 64,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic [0:ADDR_W-1] bs_addr,
  input  logic              bs_data,
  input  logic              bs_parity,
  output logic              enable,
  output logic [0:ADDR_W-1] address,
  output logic              data_in,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, HOLD} state_t;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int MX = SETUP_CYC > PULSE_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                            : (PULSE_CYC > HOLD_CYC ? PULSE_CYC : HOLD_CYC);
  localparam int PW = $clog2(MX + 1);
  state_t state, nxt;
  logic [PW-1:0] cyc;
  logic [CW-1:0] cnt;
  logic acc, perr, last, wend;
  assign acc  = state == LOAD && bs_valid;
  assign last = cnt == CW'(NUM_WORDS - 1);
`ifdef CFG_PARITY_CHECK_EN
  assign perr = acc && (^{bs_addr, bs_data, bs_parity});
`else
  logic unused_parity;
  assign unused_parity = bs_parity;
  assign perr = 1'b0;
`endif
  always_comb begin
    nxt  = state;
    wend = 1'b0;
    case (state)
      IDLE:  nxt = start ? LOAD : IDLE;
      LOAD:  if (acc) begin
               if (perr) wend = 1'b1;
               else nxt = SETUP_CYC > 0 ? SETUP : PULSE;
             end
      SETUP: if (cyc == PW'(SETUP_CYC - 1)) nxt = PULSE;
      PULSE: if (cyc == PW'(PULSE_CYC - 1)) begin
               if (HOLD_CYC > 0) nxt = HOLD;
               else wend = 1'b1;
             end
      HOLD:  if (cyc == PW'(HOLD_CYC - 1)) wend = 1'b1;
      default: nxt = IDLE;
    endcase
    if (wend) nxt = last ? IDLE : LOAD;
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state    <= IDLE;
      cyc      <= '0;
      cnt      <= '0;
      enable   <= 1'b0;
      bs_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      address  <= '0;
      data_in  <= 1'b0;
    end else begin
      state    <= nxt;
      cyc      <= nxt == state ? cyc + 1'b1 : '0;
      enable   <= nxt == PULSE;
      bs_ready <= nxt == LOAD;
      busy     <= nxt != IDLE;
      if (acc && !perr && !abort) begin
        address <= bs_addr;
        data_in <= bs_data;
      end
      if (state == IDLE && start && !abort) begin
        done <= 1'b0;
        err  <= 1'b0;
        cnt  <= '0;
      end else if (abort && state != IDLE) begin
        done <= 1'b0;
      end else begin
        if (wend) cnt <= cnt + 1'b1;
        if (wend && last) done <= 1'b1;
        if (perr) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cfg_frame_writer.sv
// tb_cfg_frame_writer: scoreboard bench driving two writer configurations (default timing and zero setup/hold)
module tb_cfg_frame_writer;
  typedef struct {int first; logic [0:6] a; logic dt;} item_t;
  logic clk = 0;
  int cyc = 0;
  int compared = 0, mismatched = 0;
  logic [1:0] prog_reset, start, abort, bs_valid, bs_data, bs_parity;
  logic [1:0] bs_ready, enable, data_in, busy, done, err;
  logic [1:0][0:6] bs_addr, address;
  item_t q[2][$];
  int done_at[2], err_at[2], ready_at[2], k[2];
  bit busy_f[2];
  logic [0:6] ea[2];
  logic ed[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_frame_writer #(.ADDR_W(7), .NUM_WORDS(4), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) u0 (
    .prog_clk(clk), .prog_reset(prog_reset[0]), .start(start[0]), .abort(abort[0]),
    .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]), .bs_addr(bs_addr[0]), .bs_data(bs_data[0]),
    .bs_parity(bs_parity[0]), .enable(enable[0]), .address(address[0]), .data_in(data_in[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]));
  cfg_frame_writer #(.ADDR_W(7), .NUM_WORDS(3), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u1 (
    .prog_clk(clk), .prog_reset(prog_reset[1]), .start(start[1]), .abort(abort[1]),
    .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]), .bs_addr(bs_addr[1]), .bs_data(bs_data[1]),
    .bs_parity(bs_parity[1]), .enable(enable[1]), .address(address[1]), .data_in(data_in[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]));

  function automatic int sc(int d); return d ? 0 : 1; endfunction
  function automatic int pc(int d); return d ? 1 : 2; endfunction
  function automatic int hc(int d); return d ? 0 : 1; endfunction
  function automatic int nw(int d); return d ? 3 : 4; endfunction

  task automatic chk(string n, int d, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", n, d, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear(int d);
    busy_f[d] = 0; done_at[d] = -1; err_at[d] = -1; ready_at[d] = 0;
    k[d] = 0; ea[d] = '0; ed[d] = 0; q[d].delete();
  endtask

  task automatic model_start(int d);
    busy_f[d] = 1; done_at[d] = -1; err_at[d] = -1; ready_at[d] = cyc + 1; k[d] = 0;
  endtask

  task automatic model_accept(int d, int e0, bit bad, logic [0:6] a, logic dt);
    int fin;
    bit pb;
    item_t it;
`ifdef CFG_PARITY_CHECK_EN
    pb = bad;
`else
    pb = 0;
`endif
    k[d]++;
    if (pb) begin
      if (err_at[d] < 0) err_at[d] = e0;
      ready_at[d] = e0;
      if (k[d] == nw(d)) done_at[d] = e0;
    end else begin
      it.first = e0 + sc(d); it.a = a; it.dt = dt;
      q[d].push_back(it);
      ea[d] = a; ed[d] = dt;
      fin = e0 + sc(d) + pc(d) + hc(d);
      ready_at[d] = fin;
      if (k[d] == nw(d)) done_at[d] = fin;
    end
  endtask

  task automatic drive_word(int d, logic [0:6] a, bit bad);
    bs_valid[d] = 1; bs_addr[d] = a; bs_data[d] = 1'($urandom);
`ifdef CFG_PARITY_CHECK_EN
    bs_parity[d] = (^{a, bs_data[d]}) ^ bad;
`else
    bs_parity[d] = 1'($urandom);
`endif
  endtask

  task automatic issue_start(int d);
    tick; start[d] = 1; model_start(d);
    tick; start[d] = 0;
  endtask

  // gap<0 picks a random idle gap after each accepted word
  task automatic run_seq(int d, int gap, int bad_idx, bit ordered);
    int g = 0, t = 0;
    bit bad;
    issue_start(d);
    while (k[d] < nw(d) && t < 300) begin
      bad = (k[d] == bad_idx);
      if (g > 0) begin bs_valid[d] = 0; g--; end
      else drive_word(d, ordered ? 7'(k[d]) : 7'($urandom), bad);
      if (bs_valid[d] && bs_ready[d]) begin
        model_accept(d, cyc + 1, bad, bs_addr[d], bs_data[d]);
        g = gap < 0 ? $urandom_range(0, 3) : gap;
      end
      tick; t++;
    end
    if (t >= 300) chk("seq_timeout", d, 32'(k[d]), 32'(nw(d)));
    repeat (10) begin
      bs_valid[d] = 1'($urandom); bs_addr[d] = 7'($urandom);
      tick;
    end
    bs_valid[d] = 0;
  endtask

  task automatic abort_mid(int d, bit use_reset);
    int t = 0, first = 0;
    bit got = 0;
    issue_start(d);
    while (!got && t < 50) begin
      drive_word(d, 7'($urandom), 0);
      if (bs_ready[d]) begin
        model_accept(d, cyc + 1, 0, bs_addr[d], bs_data[d]);
        first = cyc + 1 + sc(d);
        got = 1;
      end
      tick; t++;
    end
    bs_valid[d] = 0;
    if (!got) chk("abort_accept_timeout", d, 0, 1);
    while (cyc < first && t < 100) begin tick; t++; end
    if (use_reset) begin
      prog_reset[d] = 1; model_clear(d);
    end else begin
      abort[d] = 1; busy_f[d] = 0; done_at[d] = -1; q[d].delete();
    end
    tick;
    prog_reset[d] = 0; abort[d] = 0;
    repeat (4) tick;
  endtask

  task automatic idle_start_abort(int d);
    tick; start[d] = 1; abort[d] = 1;
    tick; start[d] = 0; abort[d] = 0;
    repeat (4) tick;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit de, be, re, ee, en;
      de = done_at[d] >= 0 && cyc >= done_at[d];
      be = busy_f[d] && !de;
      re = be && cyc >= ready_at[d];
      ee = err_at[d] >= 0 && cyc >= err_at[d];
      en = 0;
      if (q[d].size() > 0 && q[d][0].first <= cyc) begin
        en = 1;
        chk("pulse_addr", d, 32'(address[d]), 32'(q[d][0].a));
        chk("pulse_data", d, 32'(data_in[d]), 32'(q[d][0].dt));
        if (cyc == q[d][0].first + pc(d) - 1) void'(q[d].pop_front());
      end
      chk("enable", d, 32'(enable[d]), 32'(en));
      chk("address", d, 32'(address[d]), 32'(ea[d]));
      chk("data_in", d, 32'(data_in[d]), 32'(ed[d]));
      chk("busy", d, 32'(busy[d]), 32'(be));
      chk("done", d, 32'(done[d]), 32'(de));
      chk("err", d, 32'(err[d]), 32'(ee));
      chk("bs_ready", d, 32'(bs_ready[d]), 32'(re));
    end
  end

  initial begin
    prog_reset = 2'b11; start = 2'($urandom); abort = 2'($urandom);
    bs_valid = 2'($urandom); bs_data = 2'($urandom); bs_parity = 2'($urandom);
    bs_addr = 14'($urandom);
    model_clear(0); model_clear(1);
    tick;
    start = 2'($urandom); bs_valid = 2'($urandom); bs_addr = 14'($urandom);
    tick;
    prog_reset = 0; start = 0; abort = 0; bs_valid = 0;
    repeat (3) tick;
    for (int d = 0; d < 2; d++) begin
      run_seq(d, 0, -1, 0);
      run_seq(d, 3, -1, d == 0);
      run_seq(d, -1, 1, 0);
      run_seq(d, -1, -1, 0);
      abort_mid(d, 0);
      abort_mid(d, 1);
      idle_start_abort(d);
      run_seq(d, 1, nw(d) - 1, 0);
      run_seq(d, 0, -1, 1);
    end
    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
